simon_game_ctrl: RTL and testbench
==================================

Name: simon_game_ctrl

Overview:
- Game sequencer for the Simon Says datapath.
- Drives the blinker's on_off/level to play the current pattern, then collects player button presses and checks each against the pattern memory.
- Shares the single memory read address between the blinker (playback) and its own input checker (arbitrated by state).
- Advances level on success and flags win/lose; sits between the debounced buttons, blinker, simple_memory and top-level status LEDs.

Parameters:
- ms, 1_000_000, cycles per millisecond-scale unit (50 MHz clk); benches use 1
- MAX_LEVEL, 10, final level; completing it asserts win (must be 1..15)
- GAP_MS, 20, idle cycles ×ms between passing a level and the next playback
- TIMEOUT_MS, 150, input timeout ×ms (used only with INPUT_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin/restart game
- btn  in  4  debounced one-cycle press pulses, bit i = colour i
- blink_done  in  1  blinker finished playback
- blink_count  in  4  blinker's current memory address
- mem_led  in  2  pattern entry at mem_addr (combinational read)
- blink_on_off  out  1  enable to blinker
- level  out  4  current level to blinker (number of steps shown)
- mem_addr  out  4  address to simple_memory
- score  out  4  levels completed this game
- win  out  1  held high in WIN
- lose  out  1  held high in LOSE

Behaviour:
- Reset (async, reset=0): state IDLE, level=1, score=0, idx=0, blink_on_off=0, win=0, lose=0, all counters 0; mem_addr=0.
- States: IDLE, SHOW, RELEASE, WAIT_IN, CHECK, LEVEL_UP, GAP, WIN, LOSE.
- IDLE: outputs inactive. start → SHOW with level=1, score=0.
- SHOW: blink_on_off=1; mem_addr=blink_count. blink_done=1 → RELEASE.
- RELEASE: blink_on_off=0 for exactly 1 cycle, which clears the blinker. idx=0, timer=0 → WAIT_IN.
- WAIT_IN: mem_addr=idx. btn!=0 → latch btn into btn_q → CHECK. btn==0 → stay.
- CHECK: mem_addr=idx. Compare btn_q against one-hot decode of mem_led (bit mem_led set).
  - Mismatch, or btn_q not one-hot → LOSE.
  - Match and idx+1==level → LEVEL_UP.
  - Match otherwise → idx++, timer=0 → WAIT_IN.
- LEVEL_UP (1 cycle): score<=level.
  - level==MAX_LEVEL → WIN.
  - Otherwise level<=level+1, gap timer=0 → GAP.
- GAP: count to GAP_MS*ms cycles, then → SHOW.
- WIN: win=1. LOSE: lose=1. Both hold until start; start → SHOW with level=1, score=0, win/lose cleared.
- Press-to-decision latency: btn in WAIT_IN cycle N, decision registered at N+1 (CHECK), new state visible at N+2.
- btn pulses outside WAIT_IN are ignored, including during SHOW, GAP and CHECK.
- start outside IDLE/WIN/LOSE is ignored; no mid-game restart except via reset.
- Address arbitration: SHOW uses blink_count. WAIT_IN/CHECK use idx. All other states drive 0.
- All arithmetic is 4-bit; level never exceeds MAX_LEVEL, so idx never wraps.
- Reset mid-operation: immediate return to reset values, regardless of state. Blinker sees on_off=0.

Optional Feature:
- Macro INPUT_TIMEOUT_EN.
- Defined:
  - 32-bit timer counts every cycle in WAIT_IN; cleared on entry and on each accepted press.
  - Reaching TIMEOUT_MS*ms → LOSE.
  - A press and timeout in the same cycle: the press wins.
- Undefined: no timer; WAIT_IN waits indefinitely. Timer logic is absent.

Test Plan (ms=1, GAP_MS=2, MAX_LEVEL=3, TIMEOUT_MS=5, memory = {2,0,3,...}):
- reset low mid-SHOW, then high → next cycle blink_on_off=0, level=1, score=0, win=lose=0, state IDLE.
- start; pulse blink_done; press btn=4'b0100 → score=1, level=2, blink_on_off=0 for 2 cycles (GAP), then re-enters SHOW.
- Level 2: presses 4'b0100 then 4'b0010 (expected 0001) → lose=1 two cycles after the wrong press, level stays 2.
- Full game: correct presses 0100 | 0100,0001 | 0100,0001,1000 → win=1, score=3; then start → win=0, level=1, SHOW.
- In WAIT_IN, press btn=4'b0101 → LOSE. Also: btn pulse during SHOW → ignored, mem_addr tracks blink_count.
- With INPUT_TIMEOUT_EN: no press for 5 cycles after RELEASE → lose=1. Press on cycle 5 → accepted, no lose. Without the macro: 1000 idle cycles → still WAIT_IN.

Source files
------------

// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: plays the pattern via the blinker, then checks player presses.
// Optional input timeout is enabled by defining INPUT_TIMEOUT_EN.
module simon_game_ctrl #(
    parameter int unsigned ms         = 1_000_000,
    parameter int unsigned MAX_LEVEL  = 10,
    parameter int unsigned GAP_MS     = 20,
    parameter int unsigned TIMEOUT_MS = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic       blink_done,
    input  logic [3:0] blink_count,
    input  logic [1:0] mem_led,
    output logic       blink_on_off,
    output logic [3:0] level,
    output logic [3:0] mem_addr,
    output logic [3:0] score,
    output logic       win,
    output logic       lose
);

    localparam int unsigned GAP_CYC = GAP_MS * ms;
    localparam logic [3:0]  MAX_LVL = 4'(MAX_LEVEL);

    // Elaboration-time sanity of the configuration
    if (MAX_LEVEL == 0 || MAX_LEVEL > 15 || GAP_CYC == 0 || TIMEOUT_MS * ms == 0) begin : g_bad_cfg
        $error("simon_game_ctrl: illegal parameter configuration");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_SHOW,
        S_RELEASE,
        S_WAIT_IN,
        S_CHECK,
        S_LEVEL_UP,
        S_GAP,
        S_WIN,
        S_LOSE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  level_nx, score_nx;
    logic [3:0]  idx, idx_nx;
    logic [3:0]  btn_q, btn_q_nx;
    logic [31:0] gap_cnt, gap_cnt_nx;
    logic [3:0]  expect_c;
`ifdef INPUT_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_MS * ms;
    logic [31:0] timer, timer_nx;
`endif

    // Shared memory address: playback owns it in SHOW, the checker in WAIT_IN/CHECK
    always_comb begin
        mem_addr = '0;
        case (state)
            S_SHOW:             mem_addr = blink_count;
            S_WAIT_IN, S_CHECK: mem_addr = idx;
            default:            mem_addr = '0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        level_nx   = level;
        score_nx   = score;
        idx_nx     = idx;
        btn_q_nx   = btn_q;
        gap_cnt_nx = gap_cnt;
`ifdef INPUT_TIMEOUT_EN
        timer_nx   = timer;
`endif
        expect_c   = 4'b0001 << mem_led;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_nx = S_SHOW;
                    level_nx = 4'd1;
                    score_nx = '0;
                end
            end
            S_SHOW: begin
                if (blink_done) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                idx_nx   = '0;
`ifdef INPUT_TIMEOUT_EN
                timer_nx = '0;
`endif
                state_nx = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                // A press beats a coinciding timeout
                if (btn != 4'd0) begin
                    btn_q_nx = btn;
`ifdef INPUT_TIMEOUT_EN
                    timer_nx = '0;
`endif
                    state_nx = S_CHECK;
                end
`ifdef INPUT_TIMEOUT_EN
                else if (timer == 32'(TIMEOUT_CYC - 1)) begin
                    state_nx = S_LOSE;
                end else begin
                    timer_nx = timer + 32'd1;
                end
`endif
            end
            S_CHECK: begin
                // expect_c is one-hot, so a multi-bit press can never match
                if (btn_q != expect_c) begin
                    state_nx = S_LOSE;
                end else if (idx + 4'd1 == level) begin
                    state_nx = S_LEVEL_UP;
                end else begin
                    idx_nx   = idx + 4'd1;
`ifdef INPUT_TIMEOUT_EN
                    timer_nx = '0;
`endif
                    state_nx = S_WAIT_IN;
                end
            end
            S_LEVEL_UP: begin
                score_nx = level;
                if (level == MAX_LVL) begin
                    state_nx = S_WIN;
                end else begin
                    level_nx   = level + 4'd1;
                    gap_cnt_nx = '0;
                    state_nx   = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == 32'(GAP_CYC - 1)) state_nx = S_SHOW;
                else                             gap_cnt_nx = gap_cnt + 32'd1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs, the latter decoded from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            level        <= 4'd1;
            score        <= '0;
            idx          <= '0;
            btn_q        <= '0;
            gap_cnt      <= '0;
`ifdef INPUT_TIMEOUT_EN
            timer        <= '0;
`endif
            blink_on_off <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            state        <= state_nx;
            level        <= level_nx;
            score        <= score_nx;
            idx          <= idx_nx;
            btn_q        <= btn_q_nx;
            gap_cnt      <= gap_cnt_nx;
`ifdef INPUT_TIMEOUT_EN
            timer        <= timer_nx;
`endif
            blink_on_off <= (state_nx == S_SHOW);
            win          <= (state_nx == S_WIN);
            lose         <= (state_nx == S_LOSE);
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed bench for simon_game_ctrl with a small pattern memory model (ms=1, GAP_MS=2, MAX_LEVEL=3).
module tb_simon_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic       blink_done;
    logic [3:0] blink_count;
    logic [1:0] mem_led;
    logic       blink_on_off;
    logic [3:0] level;
    logic [3:0] mem_addr;
    logic [3:0] score;
    logic       win;
    logic       lose;

    logic [1:0] mem [16];
    int errors = 0;
    int checks = 0;

    assign mem_led = mem[mem_addr];

    always #5 clk = ~clk;

    simon_game_ctrl #(
        .ms(1), .MAX_LEVEL(3), .GAP_MS(2), .TIMEOUT_MS(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn),
        .blink_done(blink_done), .blink_count(blink_count), .mem_led(mem_led),
        .blink_on_off(blink_on_off), .level(level), .mem_addr(mem_addr),
        .score(score), .win(win), .lose(lose)
    );

    typedef struct {
        logic       start;
        logic [3:0] btn;
        logic       bd;
        logic [3:0] bc;
        logic       bo;
        logic [3:0] lvl;
        logic [3:0] addr;
        logic [3:0] sc;
        logic       w;
        logic       l;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic s, logic [3:0] b, logic bd, logic [3:0] bc,
                                logic bo, logic [3:0] lv, logic [3:0] ad,
                                logic [3:0] sc, logic w, logic l);
        vec_t v;
        v.start = s;  v.btn = b;    v.bd = bd;   v.bc = bc;
        v.bo = bo;    v.lvl = lv;   v.addr = ad; v.sc = sc;
        v.w = w;      v.l = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plays one level from SHOW: finish playback, enter the correct presses, pass LEVEL_UP
    task automatic play_level(input int lvl);
        blink_done = 1'b1; step();
        blink_done = 1'b0; step();
        for (int i = 0; i < lvl; i++) begin
            btn = 4'b0001 << mem[i];
            step();
            btn = 4'b0000;
            step();
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'd1;
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;

        //          start btn     bd  bc   | bo  lvl  addr sc   w  l
        vecs[0]  = mk(0, 4'b0000, 0, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[1]  = mk(1, 4'b0000, 0, 4'd0,   1, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[2]  = mk(0, 4'b0001, 0, 4'd0,   1, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[3]  = mk(0, 4'b0000, 0, 4'd5,   1, 4'd1, 4'd5, 4'd0, 0, 0);
        vecs[4]  = mk(0, 4'b0000, 1, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[5]  = mk(0, 4'b0000, 0, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[6]  = mk(1, 4'b0000, 0, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[7]  = mk(0, 4'b0100, 0, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[8]  = mk(0, 4'b0000, 0, 4'd0,   0, 4'd1, 4'd0, 4'd0, 0, 0);
        vecs[9]  = mk(0, 4'b0000, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[10] = mk(0, 4'b0000, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[11] = mk(0, 4'b0000, 0, 4'd0,   1, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[12] = mk(0, 4'b0010, 0, 4'd0,   1, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[13] = mk(0, 4'b0000, 1, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[14] = mk(0, 4'b0000, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[15] = mk(0, 4'b0100, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 0);
        vecs[16] = mk(0, 4'b0000, 0, 4'd0,   0, 4'd2, 4'd1, 4'd1, 0, 0);
        vecs[17] = mk(0, 4'b0010, 0, 4'd0,   0, 4'd2, 4'd1, 4'd1, 0, 0);
        vecs[18] = mk(0, 4'b0000, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 1);
        vecs[19] = mk(0, 4'b0100, 0, 4'd0,   0, 4'd2, 4'd0, 4'd1, 0, 1);
        vecs[20] = mk(1, 4'b0000, 0, 4'd0,   1, 4'd1, 4'd0, 4'd0, 0, 0);

        reset = 1'b0; start = 1'b0; btn = 4'b0000; blink_done = 1'b0; blink_count = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("reset_on_off", 32'(blink_on_off), 32'd0);
        chk("reset_level",  32'(level),        32'd1);
        chk("reset_score",  32'(score),        32'd0);

        // Level 1 pass, GAP, then a wrong press at level 2
        for (int i = 0; i < 21; i++) begin
            start = vecs[i].start; btn = vecs[i].btn;
            blink_done = vecs[i].bd; blink_count = vecs[i].bc;
            step();
            chk($sformatf("vec%0d.on_off", i), 32'(blink_on_off), 32'(vecs[i].bo));
            chk($sformatf("vec%0d.level", i),  32'(level),        32'(vecs[i].lvl));
            chk($sformatf("vec%0d.addr", i),   32'(mem_addr),     32'(vecs[i].addr));
            chk($sformatf("vec%0d.score", i),  32'(score),        32'(vecs[i].sc));
            chk($sformatf("vec%0d.win", i),    32'(win),          32'(vecs[i].w));
            chk($sformatf("vec%0d.lose", i),   32'(lose),         32'(vecs[i].l));
        end
        start = 1'b0; btn = 4'b0000; blink_done = 1'b0; blink_count = 4'd0;

        // Advance to level 2 SHOW, then reset mid-SHOW
        play_level(1);
        chk("l1_gap_score", 32'(score), 32'd1);
        chk("l1_gap_level", 32'(level), 32'd2);
        step();
        chk("l1_gap2_on_off", 32'(blink_on_off), 32'd0);
        step();
        chk("l2_show_on_off", 32'(blink_on_off), 32'd1);
        blink_count = 4'd7;
        #1;
        chk("show_addr_tracks", 32'(mem_addr), 32'd7);
        reset = 1'b0;
        #1;
        chk("async_rst_on_off", 32'(blink_on_off), 32'd0);
        chk("async_rst_level",  32'(level),        32'd1);
        chk("async_rst_score",  32'(score),        32'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_on_off", 32'(blink_on_off), 32'd0);
        chk("post_rst_idle_addr", 32'(mem_addr), 32'd0);
        chk("post_rst_win_lose", 32'({win, lose}), 32'd0);
        blink_count = 4'd0;

        // Full game to WIN
        start = 1'b1; step(); start = 1'b0;
        for (int lv = 1; lv <= 3; lv++) begin
            play_level(lv);
            if (lv < 3) begin
                chk($sformatf("game_l%0d_score", lv), 32'(score), 32'(lv));
                chk($sformatf("game_l%0d_level", lv), 32'(level), 32'(lv + 1));
                step(); step();
                chk($sformatf("game_l%0d_reshow", lv), 32'(blink_on_off), 32'd1);
            end
        end
        chk("win_flag",  32'(win),   32'd1);
        chk("win_score", 32'(score), 32'd3);
        chk("win_level", 32'(level), 32'd3);
        step();
        chk("win_held", 32'(win), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_win",    32'(win),          32'd0);
        chk("restart_level",  32'(level),        32'd1);
        chk("restart_on_off", 32'(blink_on_off), 32'd1);
        chk("restart_score",  32'(score),        32'd0);

        // Non-one-hot press loses
        blink_done = 1'b1; step(); blink_done = 1'b0; step();
        btn = 4'b0101; step(); btn = 4'b0000;
        chk("multi_check_lose", 32'(lose), 32'd0);
        step();
        chk("multi_lose", 32'(lose), 32'd1);

        start = 1'b1; step(); start = 1'b0;
        blink_done = 1'b1; step(); blink_done = 1'b0; step();
`ifdef INPUT_TIMEOUT_EN
        repeat (4) step();
        chk("timeout_pre", 32'(lose), 32'd0);
        step();
        chk("timeout_lose", 32'(lose), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        blink_done = 1'b1; step(); blink_done = 1'b0; step();
        repeat (4) step();
        btn = 4'b0100; step(); btn = 4'b0000;
        chk("late_press_lose", 32'(lose), 32'd0);
        step(); step();
        chk("late_press_score", 32'(score), 32'd1);
        chk("late_press_nolose", 32'(lose), 32'd0);
`else
        repeat (1000) step();
        chk("idle_wait_lose",   32'(lose),         32'd0);
        chk("idle_wait_on_off", 32'(blink_on_off), 32'd0);
        btn = 4'b0100; step(); btn = 4'b0000;
        step(); step();
        chk("idle_wait_score", 32'(score), 32'd1);
        chk("idle_wait_level", 32'(level), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
